// File: rtl/onehot_pkg.sv
// Shared one-hot helpers for the one-hot mux/demux family.
// Helpers work on a fixed MAX_N-wide vector; callers zero-extend in and size-cast out.
package onehot_pkg;

    localparam int unsigned MAX_N = 64;

    typedef logic [MAX_N-1:0] vec_t;

    // Isolates the lowest set bit (priority select); zero in gives zero out.
    function automatic vec_t lowest_set(input vec_t v);
        return v & (~v + MAX_N'(1));
    endfunction

    // True when zero or exactly one bit is set.
    function automatic logic onehot_ok(input vec_t v);
        return (v & (v - MAX_N'(1))) == '0;
    endfunction

endpackage

// File: rtl/onehot_demux_slot.sv
// One storage entry (data, destination, valid) of the demux pipeline.
// Used for both the main and the skid register.
module onehot_demux_slot #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] wdata,
    input  logic [N-1:0]  wdest,
    output logic [DW-1:0] data,
    output logic [N-1:0]  dest,
    output logic          valid
);

    // Load wins over clear so a drain and refill in the same cycle keeps the entry full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            dest  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= wdata;
            dest  <= wdest;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/onehot_demux_reg.sv
// Registered one-hot stream demultiplexer with a skid slot; i_ready is a flop.
// Optional macro ONEHOT_DEMUX_SEL_CHECK_EN: drop multi-hot selects and raise sticky err.
module onehot_demux_reg
    import onehot_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    sel,
    input  logic [DW-1:0]   i,
    input  logic            i_valid,
    output logic            i_ready,
    output logic [N*DW-1:0] o,
    output logic [N-1:0]    o_valid,
    input  logic [N-1:0]    o_ready,
    output logic            err
);

    logic [DW-1:0] main_data, skid_data, main_wdata;
    logic [N-1:0]  main_dest, skid_dest, main_wdest, sel_dest;
    logic          main_valid, skid_valid;
    logic          accept, legal, store, main_drain;
    logic          main_load, skid_load;

    assign accept     = i_valid & i_ready;
    assign main_drain = main_valid & (|(main_dest & o_ready));

`ifdef ONEHOT_DEMUX_SEL_CHECK_EN
    assign sel_dest = sel;
    assign legal    = (sel != '0) && onehot_ok(MAX_N'(sel));

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (accept && (sel != '0) && !onehot_ok(MAX_N'(sel)))
            err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (onehot_ok(MAX_N'(o_valid)));
    end
`else
    assign sel_dest = N'(lowest_set(MAX_N'(sel)));
    assign legal    = sel != '0;
    assign err      = 1'b0;
`endif

    assign store = accept & legal;

    // Skid is only ever occupied while main is, so an empty main implies an empty skid.
    always_comb begin
        main_wdata = skid_valid ? skid_data : i;
        main_wdest = skid_valid ? skid_dest : sel_dest;
        main_load  = (main_drain & skid_valid) | (store & (~main_valid | main_drain));
        skid_load  = store & main_valid & ~main_drain;
    end

    onehot_demux_slot #(.DW(DW), .N(N)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_drain),
        .wdata (main_wdata),
        .wdest (main_wdest),
        .data  (main_data),
        .dest  (main_dest),
        .valid (main_valid)
    );

    onehot_demux_slot #(.DW(DW), .N(N)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (main_drain),
        .wdata (i),
        .wdest (sel_dest),
        .data  (skid_data),
        .dest  (skid_dest),
        .valid (skid_valid)
    );

    // Tracks "skid empty" one cycle ahead so the flop equals ~skid_valid.
    always_ff @(posedge clk) begin
        if (rst)
            i_ready <= 1'b1;
        else if (skid_load)
            i_ready <= 1'b0;
        else if (main_drain)
            i_ready <= 1'b1;
    end

    always_comb begin
        o_valid = main_valid ? main_dest : '0;
        o       = '0;
        for (int unsigned j = 0; j < N; j++)
            if (o_valid[j])
                o[j*DW +: DW] = main_data;
    end

endmodule

// File: tb/tb_onehot_demux_reg.sv
// Directed self-checking bench for onehot_demux_reg (N=4, DW=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_onehot_demux_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic [7:0]  i;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] o;
    logic [3:0]  o_valid;
    logic [3:0]  o_ready;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    onehot_demux_reg #(.DW(8), .N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .i       (i),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o       (o),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .err     (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b1; sel = 4'b0001; i = 8'h99; o_ready = 4'b0000;
        tick();
        tick();
        check("rst_ready", i_ready, 1);
        check("rst_ovalid", o_valid, 0);
        check("rst_o", o, 0);
        check("rst_err", err, 0);
        rst = 1'b0; i_valid = 1'b0;

        // Streaming: one beat per clock, lanes cycling
        o_ready = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            i = 8'h11 + 8'(k); sel = 4'(1 << (k % 4)); i_valid = 1'b1;
            check("stream_ready", i_ready, 1);
            tick();
            check("stream_ovalid", o_valid, 64'(1 << (k % 4)));
            check("stream_o", o, 64'(8'h11 + k) << (8 * (k % 4)));
        end
        i_valid = 1'b0;
        tick();
        check("stream_idle", o_valid, 0);

        // Backpressure on lane 2
        o_ready = 4'b1011; sel = 4'b0100; i = 8'hA1; i_valid = 1'b1;
        tick();
        check("bp_ovalid", o_valid, 4'b0100);
        check("bp_hold_a1", o, 32'h00A1_0000);
        check("bp_ready_hi", i_ready, 1);
        i = 8'hA2;
        tick();
        check("bp_ready_lo", i_ready, 0);
        check("bp_still_a1", o, 32'h00A1_0000);
        i = 8'hA3;
        tick();
        tick();
        tick();
        check("bp_stable_a1", o, 32'h00A1_0000);
        check("bp_stable_rdy", i_ready, 0);
        o_ready = 4'b1111;
        tick();
        check("bp_a2", o, 32'h00A2_0000);
        check("bp_a2_valid", o_valid, 4'b0100);
        check("bp_ready_back", i_ready, 1);
        tick();
        check("bp_a3", o, 32'h00A3_0000);
        i_valid = 1'b0;
        tick();
        check("bp_done", o_valid, 0);

        // Head-of-line blocking: lane 3 waits behind stalled lane 1
        o_ready = 4'b1101; sel = 4'b0010; i = 8'h31; i_valid = 1'b1;
        tick();
        sel = 4'b1000; i = 8'h32;
        tick();
        i_valid = 1'b0;
        check("hol_blocked", o_valid, 4'b0010);
        check("hol_o31", o, 32'h0000_3100);
        tick();
        check("hol_still", o_valid, 4'b0010);
        o_ready = 4'b1111;
        tick();
        check("hol_lane3", o_valid, 4'b1000);
        check("hol_o32", o, 32'h3200_0000);
        tick();
        check("hol_done", o_valid, 0);

        // Zero select drops the beat
        sel = 4'b0000; i = 8'h55; i_valid = 1'b1;
        check("zero_ready_pre", i_ready, 1);
        tick();
        check("zero_ovalid", o_valid, 0);
        check("zero_err", err, 0);
        check("zero_ready", i_ready, 1);
        sel = 4'b0001; i = 8'h56;
        tick();
        check("zero_next_valid", o_valid, 4'b0001);
        check("zero_next_o", o, 32'h0000_0056);
        i_valid = 1'b0;
        tick();

        // Multi-hot select
        sel = 4'b0110; i = 8'h77; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
`ifdef ONEHOT_DEMUX_SEL_CHECK_EN
        check("mh_dropped", o_valid, 0);
        check("mh_err", err, 1);
        sel = 4'b0001; i = 8'h78; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("mh_legal_valid", o_valid, 4'b0001);
        check("mh_legal_o", o, 32'h0000_0078);
        check("mh_err_sticky", err, 1);
`else
        check("mh_lane1", o_valid, 4'b0010);
        check("mh_o", o, 32'h0000_7700);
        check("mh_err_off", err, 0);
`endif
        tick();

        // Reset with both slots full discards the held beats
        o_ready = 4'b0000; sel = 4'b0001; i = 8'hC1; i_valid = 1'b1;
        tick();
        i = 8'hC2;
        tick();
        i_valid = 1'b0;
        check("full_ready", i_ready, 0);
        check("full_ovalid", o_valid, 4'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_ovalid", o_valid, 0);
        check("rst2_o", o, 0);
        check("rst2_ready", i_ready, 1);
        check("rst2_err", err, 0);
        o_ready = 4'b1111;
        tick();
        check("rst2_empty1", o_valid, 0);
        tick();
        check("rst2_empty2", o_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onehot_demux_reg.md
Name: onehot_demux_reg

Overview:
- Registered stream demultiplexer: routes one valid/ready input stream to one of N output streams, selected by a one-hot select that travels with each beat.
- Counterpart of the one-hot mux: the mux gathers N lanes into one, this block fans one stream out to N lanes.
- Full-throughput pipeline register with a skid slot, so the input ready is a pure register output.
- Sits between a shared producer and N per-lane consumers.

Parameters:
- DW, 8, data width per lane in bits.
- N, 4, number of output lanes (>=2).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- sel  input  N  one-hot destination of the current input beat.
- i  input  DW  input data.
- i_valid  input  1  input beat valid.
- i_ready  output  1  block can accept; registered.
- o  output  N*DW  lane j data on o[(j+1)*DW-1 -: DW].
- o_valid  output  N  per-lane valid; at most one bit set.
- o_ready  input  N  per-lane ready.
- err  output  1  sticky illegal-select flag (see Optional Feature).

Behaviour:
- Storage: main register (data, dest) and skid register (data, dest), each with a valid bit.
- Reset (rst=1 at an edge): both valid bits clear, i_ready=1, o_valid=0, o=0, err=0. Reset mid-transfer discards held beats without emitting them.
- Accept: the input is accepted when i_valid&i_ready.
  - Main empty, or main draining this cycle: beat loads main.
  - Otherwise: beat loads skid, and i_ready drops next cycle.
- Drain: main drains when o_valid[dest]&o_ready[dest]. On drain, skid (if valid) moves to main and i_ready returns to 1 next cycle.
- i_ready is registered and equals "skid empty". It never depends combinationally on o_ready.
- Latency: beat accepted at edge k is visible on o_valid/o at cycle k+1. Sustained 1 beat/clk when the destination lane is always ready.
- Outputs:
  - o_valid = main_valid ? main_dest : 0.
  - Lane dest slice of o carries main data; all other slices are 0.
  - o is 0 when main is empty.
- Ordering: strict arrival order across all lanes. A stalled lane blocks subsequent beats to other lanes (head-of-line blocking; intended).
- sel==0 on an accepted beat: beat is consumed and dropped, never stored. i_ready is unaffected.
- Multi-hot sel, macro off: lowest set bit is the destination (priority select).
- o_valid/o/dest are stable while o_valid is set and o_ready[dest]=0. i/sel are sampled only on accept.
- Simultaneous drain of main and accept with skid empty: new beat goes directly to main, no bubble.

Optional Feature:
- Macro ONEHOT_DEMUX_SEL_CHECK_EN.
- Defined:
  - An accepted beat with multi-hot sel ($countones>1) is dropped like sel==0, and err sets.
  - err stays 1 until rst.
  - Simulation-only assertion additionally flags o_valid not being one-hot-or-zero.
- Undefined: err tied to 0; multi-hot handled by lowest-bit priority.

Decomposition:
- Package onehot_pkg:
  - lowest-set-bit one-hot function, parameterised via a width-generic helper.
  - onehot-valid check function (zero or exactly one bit set), shared with the mux checkers.
- One sub-module is natural: onehot_demux_slot, a single storage entry (data+dest+valid with load/clear). It is instantiated twice, for main and skid.
- Lane slicing and masking stay in the top.

Test Plan:
- Reset: hold rst 2 cycles with i_valid=1 -> i_ready=1, o_valid=0, o=0, err=0. Apply rst while both slots are full -> nothing emitted afterwards.
- Streaming: N=4, o_ready=4'b1111, send i=0x11..0x18 with sel cycling 0001,0010,0100,1000.
  - Beat k appears one cycle after accept on lane k%4 with correct data.
  - Other slices are 0.
  - 1 beat/clk, i_ready never drops.
- Backpressure: sel=0100, o_ready[2]=0 for 5 cycles, send 0xA1,0xA2,0xA3.
  - 0xA1 is held on lane 2.
  - 0xA2 goes to skid; i_ready=0 from the next cycle.
  - Release o_ready: 0xA1, 0xA2, 0xA3 emitted in order, no loss or duplicate.
- Head-of-line: beat 0x31 to lane 1 (o_ready[1]=0), then beat 0x32 to lane 3 (o_ready[3]=1) -> lane 3 sees nothing until 0x31 drains.
- Zero select: accept beat 0x55 with sel=0000 -> no o_valid, err=0, following beat 0x56/sel=0001 emitted normally.
- Multi-hot sel=0110, data 0x77:
  - Macro off: emitted on lane 1 only.
  - Macro on: dropped, err=1 and remains 1 through further legal traffic until rst.
